// File: rtl/hls_run_sequencer.sv
// Batch run controller for a Bambu accelerator: resets it, starts it, times each run and queues
// one {status,cycles} record per run in a FWFT FIFO. Define HLS_RUNSEQ_TIMEOUT_EN for the watchdog.
module hls_run_sequencer #(
  parameter int CNT_W      = 32,
  parameter int RUNS_W     = 8,
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 200000000,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                go,
  input  logic [RUNS_W-1:0]   num_runs,
  output logic                busy,
  output logic                batch_done,
  output logic                acc_reset,
  output logic                start_port,
  input  logic                done_port,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [CNT_W+1:0]    res_data
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNTF_W = PTR_W + 1;
  localparam int RC_W   = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int REC_W  = CNT_W + 2;
  localparam logic [CNTF_W-1:0] DEPTH_C = CNTF_W'(FIFO_DEPTH);
  localparam logic [RC_W-1:0]   RC_LAST = RC_W'(RST_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARST, S_START, S_WAIT, S_LOG, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [RUNS_W-1:0]   runs_left_q, runs_left_d;
  logic [RC_W-1:0]     rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0]    cyc_q, cyc_d, cyc_inc;
  logic [REC_W-1:0]    rec_q, rec_d;
  logic                busy_q, busy_d;
  logic                batch_done_q, batch_done_d;
  logic                acc_reset_q, acc_reset_d;
  logic                start_port_q, start_port_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTF_W-1:0]   count_q, count_d;
  logic [REC_W-1:0]    fifo_mem_q [FIFO_DEPTH];
  logic                push, pop, fifo_full;

`ifdef HLS_RUNSEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  assign fifo_full = (count_q == DEPTH_C);
  assign pop       = (count_q != '0) && res_ready;
  // The counter sticks at all-ones rather than wrapping on very long runs.
  assign cyc_inc   = (&cyc_q) ? cyc_q : cyc_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    runs_left_d = runs_left_q;
    rst_cnt_d   = rst_cnt_q;
    cyc_d       = cyc_q;
    rec_d       = rec_q;
    push        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          runs_left_d = num_runs;
          state_d     = (num_runs == '0) ? S_DONE : S_ARST;
        end
      end
      S_ARST: begin
        if (rst_cnt_q == RC_LAST) begin
          rst_cnt_d = '0;
          state_d   = S_START;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      S_START: begin
        cyc_d   = CNT_W'(1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // cyc_q counts the start cycle, so the done cycle itself adds one more.
        if (done_port) begin
          rec_d   = {2'b01, cyc_inc};
          state_d = S_LOG;
        end
`ifdef HLS_RUNSEQ_TIMEOUT_EN
        else if (cyc_q == TIMEOUT_C) begin
          rec_d   = {2'b10, TIMEOUT_C};
          state_d = S_LOG;
        end
`endif
        else begin
          cyc_d = cyc_inc;
        end
      end
      S_LOG: begin
        if (!fifo_full) begin
          push        = 1'b1;
          runs_left_d = runs_left_q - 1'b1;
          state_d     = (runs_left_q == RUNS_W'(1)) ? S_DONE : S_ARST;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with the state register.
    busy_d       = (state_d != S_IDLE);
    batch_done_d = (state_d == S_DONE);
    acc_reset_d  = (state_d != S_ARST);
    start_port_d = (state_d == S_START);

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      runs_left_q  <= '0;
      rst_cnt_q    <= '0;
      cyc_q        <= '0;
      rec_q        <= '0;
      busy_q       <= 1'b0;
      batch_done_q <= 1'b0;
      acc_reset_q  <= 1'b0;
      start_port_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      runs_left_q  <= runs_left_d;
      rst_cnt_q    <= rst_cnt_d;
      cyc_q        <= cyc_d;
      rec_q        <= rec_d;
      busy_q       <= busy_d;
      batch_done_q <= batch_done_d;
      acc_reset_q  <= acc_reset_d;
      start_port_q <= start_port_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo_mem_q[wr_ptr_q] <= rec_q;
  end

  assign busy       = busy_q;
  assign batch_done = batch_done_q;
  assign acc_reset  = acc_reset_q;
  assign start_port = start_port_q;
  assign res_valid  = (count_q != '0);
  // Empty FIFO presents zero so stale entries never leak out after a reset.
  assign res_data   = res_valid ? fifo_mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_hls_run_sequencer.sv
// Randomized self-checking bench for hls_run_sequencer against a behavioural run/FIFO model.
module tb_hls_run_sequencer;
  localparam int CNT_W = 16, RUNS_W = 4, RSTC = 2, TMO = 20, DEPTH = 2;

  logic clock = 1'b0, reset = 1'b0, go = 1'b0, done_port = 1'b0, res_ready = 1'b0;
  logic [RUNS_W-1:0] num_runs = '0;
  logic busy, batch_done, acc_reset, start_port, res_valid;
  logic [CNT_W+1:0] res_data;

  hls_run_sequencer #(.CNT_W(CNT_W), .RUNS_W(RUNS_W), .RST_CYCLES(RSTC),
                      .TIMEOUT(TMO), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .go(go), .num_runs(num_runs), .busy(busy),
    .batch_done(batch_done), .acc_reset(acc_reset), .start_port(start_port),
    .done_port(done_port), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data));

  always #5 clock = ~clock;

  int total = 0, bad = 0;
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] sat_inc(logic [15:0] x);
    return (x == 16'hFFFF) ? x : x + 16'd1;
  endfunction

  // ---------------- behavioural model ----------------
  int m_low = 0, m_runs = 0;
  bit m_start = 0, m_wait = 0, m_pend = 0, m_bd = 0, m_alive = 0;
  logic [15:0] m_el = '0;
  logic [17:0] m_pv = '0;
  logic [17:0] mq[$];

  always @(posedge clock or negedge reset) begin : model
    logic popping, room, nx_bd;
    if (!reset) begin
      m_low = 0; m_runs = 0; m_start = 0; m_wait = 0; m_pend = 0; m_bd = 0; m_alive = 0;
      m_el = '0; mq.delete();
    end else begin
      popping = (mq.size() > 0) && res_ready;
      room    = (mq.size() < DEPTH);
      nx_bd   = 1'b0;
      m_alive = 1;
      if (m_bd) begin
      end else if (m_low > 0) begin
        m_low--;
        if (m_low == 0) m_start = 1;
      end else if (m_start) begin
        m_start = 0; m_wait = 1; m_el = 16'd1;
      end else if (m_wait) begin
        if (done_port) begin
          m_pv = {2'b01, sat_inc(m_el)}; m_wait = 0; m_pend = 1;
        end
`ifdef HLS_RUNSEQ_TIMEOUT_EN
        else if (m_el == 16'(TMO)) begin
          m_pv = {2'b10, 16'(TMO)}; m_wait = 0; m_pend = 1;
        end
`endif
        else m_el = sat_inc(m_el);
      end else if (m_pend) begin
        if (room) begin
          mq.push_back(m_pv); m_pend = 0; m_runs--;
          if (m_runs == 0) nx_bd = 1'b1; else m_low = RSTC;
        end
      end else if (go) begin
        m_runs = int'(num_runs);
        if (m_runs == 0) nx_bd = 1'b1; else m_low = RSTC;
      end
      m_bd = nx_bd;
      if (popping) void'(mq.pop_front());
    end
  end

  // ---------------- compare process ----------------
  logic [17:0] popped[$];
  int start_cnt = 0, arst_low_cnt = 0;
  always @(negedge clock) begin
    check("busy", 64'(busy), 64'((m_low > 0) || m_start || m_wait || m_pend || m_bd));
    check("batch_done", 64'(batch_done), 64'(m_bd));
    check("acc_reset", 64'(acc_reset), 64'(m_alive && (m_low == 0)));
    check("start_port", 64'(start_port), 64'(m_start));
    check("res_valid", 64'(res_valid), 64'(mq.size() > 0));
    if (mq.size() > 0) check("res_data", 64'(res_data), 64'(mq[0]));
    else if (!reset) check("res_data_rst", 64'(res_data), 64'd0);
    if (reset && res_valid && res_ready) popped.push_back(res_data);
    if (reset && start_port) start_cnt++;
    if (reset && !acc_reset) arst_low_cnt++;
  end

  // ---------------- accelerator stand-in ----------------
  int lat_q[$];
  bit rand_lat = 0, noise = 0, acc_on = 0;
  int acc_cnt = 0;

  function automatic int pick_lat();
`ifdef HLS_RUNSEQ_TIMEOUT_EN
    if ($urandom_range(0, 5) == 0) return 0;
`endif
    return int'($urandom_range(1, 25));
  endfunction

  always @(posedge clock) begin : accel
    int l;
    #2;
    if (!reset) begin
      acc_on = 0; done_port = 1'b0;
    end else if (start_port) begin
      if (lat_q.size() > 0) l = lat_q.pop_front();
      else if (rand_lat) l = pick_lat();
      else l = 0;
      acc_on = (l > 0); acc_cnt = l;
      done_port = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    end else if (acc_on) begin
      acc_cnt--;
      done_port = (acc_cnt == 0);
      if (acc_cnt == 0) acc_on = 0;
    end else begin
      done_port = (noise && !acc_reset) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock); #2;
  endtask

  task automatic wait_bd(int maxc, string nm);
    int n = 0;
    while (!batch_done && n < maxc) begin tick(); n++; end
    check({nm, "_batch_done"}, 64'(batch_done), 64'd1);
  endtask

  task automatic pulse_go(int n);
    num_runs = RUNS_W'(n); go = 1'b1; tick(); go = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [17:0] e;
    int s0, a0;
    repeat (3) tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_acc_reset", 64'(acc_reset), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_res_data", 64'(res_data), 64'd0);
    reset = 1'b1; tick();

    // one run, done 9 cycles after start
    lat_q.push_back(9); pulse_go(1);
    wait_bd(200, "t1");
    e = {2'b01, 16'd10};
    check("t1_res_valid", 64'(res_valid), 64'd1);
    check("t1_res_data", 64'(res_data), 64'(e));
    check("t1_model_size", 64'(mq.size()), 64'd1);
    if (mq.size() > 0) check("t1_model_rec", 64'(mq[0]), 64'(e));
    res_ready = 1'b1; tick(); res_ready = 1'b0; tick();

    // three runs of latency 5 drained as they arrive
    popped.delete(); s0 = start_cnt; a0 = arst_low_cnt;
    res_ready = 1'b1; lat_q = '{5, 5, 5}; pulse_go(3);
    wait_bd(300, "t2"); tick(); tick();
    check("t2_count", 64'(popped.size()), 64'd3);
    foreach (popped[i]) check("t2_rec", 64'(popped[i]), 64'({2'b01, 16'd6}));
    check("t2_starts", 64'(start_cnt - s0), 64'd3);
    check("t2_arst_low", 64'(arst_low_cnt - a0), 64'd6);

    // zero runs, go held into the busy cycle
    s0 = start_cnt; res_ready = 1'b0;
    num_runs = '0; go = 1'b1; tick();
    check("t5_busy", 64'(busy), 64'd1);
    check("t5_batch_done", 64'(batch_done), 64'd1);
    tick(); go = 1'b0;
    check("t5_idle", 64'(busy), 64'd0);
    tick();
    check("t5_no_start", 64'(start_cnt - s0), 64'd0);
    check("t5_no_record", 64'(res_valid), 64'd0);

    // FIFO back-pressure: four runs into a two-entry FIFO
    popped.delete(); lat_q = '{3, 4, 5, 6}; pulse_go(4);
    repeat (80) tick();
    check("t4_stall_busy", 64'(busy), 64'd1);
    check("t4_stall_head", 64'(res_data), 64'({2'b01, 16'd4}));
    check("t4_model_full", 64'(mq.size()), 64'd2);
    res_ready = 1'b1;
    wait_bd(300, "t4"); tick(); tick();
    check("t4_count", 64'(popped.size()), 64'd4);
    foreach (popped[i]) check("t4_rec", 64'(popped[i]), 64'({2'b01, 16'(i + 4)}));

    // accelerator never finishes
    popped.delete(); lat_q = '{0}; s0 = start_cnt;
    pulse_go(1);
`ifdef HLS_RUNSEQ_TIMEOUT_EN
    wait_bd(200, "t3"); tick(); tick();
    check("t3_count", 64'(popped.size()), 64'd1);
    if (popped.size() > 0) check("t3_rec", 64'(popped[0]), 64'({2'b10, 16'd20}));
    lat_q = '{0, 0}; pulse_go(2);
    repeat (10) tick();
`else
    repeat (60) tick();
    check("t3_stuck_busy", 64'(busy), 64'd1);
    check("t3_no_record", 64'(res_valid), 64'd0);
    check("t3_one_start", 64'(start_cnt - s0), 64'd1);
`endif

    // asynchronous reset in the middle of a run
    reset = 1'b0; lat_q.delete(); #1;
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_acc_reset", 64'(acc_reset), 64'd0);
    check("t6_start_port", 64'(start_port), 64'd0);
    check("t6_res_valid", 64'(res_valid), 64'd0);
    tick(); reset = 1'b1; tick();
    popped.delete(); lat_q = '{7}; pulse_go(1);
    wait_bd(200, "t6"); tick(); tick();
    check("t6_count", 64'(popped.size()), 64'd1);
    if (popped.size() > 0) check("t6_rec", 64'(popped[0]), 64'({2'b01, 16'd8}));

    // randomized batches with noisy done_port, random go and random back-pressure
    rand_lat = 1; noise = 1;
    for (int b = 0; b < 25; b++) begin
      int n;
      pulse_go(int'($urandom_range(0, 5)));
      n = 0;
      while (!batch_done && n < 3000) begin
        res_ready = 1'($urandom_range(0, 1));
        go = ($urandom_range(0, 3) == 0);
        num_runs = RUNS_W'($urandom_range(0, 5));
        tick(); n++;
      end
      go = 1'b0;
      check("rand_batch_done", 64'(batch_done), 64'd1);
      res_ready = 1'b1; tick();
    end
    res_ready = 1'b1; repeat (5) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
